// File: rtl/hazard_sched.sv
// hazard_sched: stall/flush sequencing, operand and store-data forwarding selects and
// mul/div occupancy for the 5-stage MIPS pipeline. Define HAZ_STORE_FWD_EN for load->store forwarding.
module hazard_sched #(
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_sw,
  input  logic [4:0] id_dst,
  input  logic       id_reg_write,
  input  logic       id_mem_to_reg,
  input  logic       id_is_muldiv,
  input  logic       id_reads_hilo,
  input  logic       ex_branch_taken,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       fwd_f,
  output logic       muldiv_busy,
  output logic       md_state
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       is_sw;
  } stage_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  localparam logic [5:0] LAT_M1 = 6'(MULDIV_LAT - 1);

  stage_t    ex_q, mem_q, wb_q, id_entry;
  md_state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic ld_rs, ld_rt, load_use, md_haz, stall, launch;

  // The ID instruction advances into EX on every edge unless idex_bubble is high;
  // the upstream IF/ID register holds while ifid_write_en is low.
  always_comb begin
    id_entry = '0;
    if (id_valid && !idex_bubble) begin
      id_entry.valid      = 1'b1;
      id_entry.dst        = id_dst;
      id_entry.reg_write  = id_reg_write;
      id_entry.mem_to_reg = id_mem_to_reg;
      id_entry.rs         = id_rs;
      id_entry.rt         = id_rt;
      id_entry.use_rs     = id_use_rs;
      id_entry.use_rt     = id_use_rt;
      id_entry.is_sw      = id_is_sw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src,
                                         input stage_t ex, input stage_t mem, input stage_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.valid && use_src && src != 5'd0) begin
      if (mem.valid && mem.reg_write && !mem.mem_to_reg && mem.dst == src)
        sel = 2'b10;
      else if (wb.valid && wb.reg_write && wb.dst == src)
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_q.rs, ex_q.use_rs, ex_q, mem_q, wb_q);
  assign fwd_b = fwd_sel(ex_q.rt, ex_q.use_rt, ex_q, mem_q, wb_q);

  assign ld_rs = id_valid && ex_q.valid && ex_q.reg_write && ex_q.mem_to_reg &&
                 ex_q.dst != 5'd0 && id_use_rs && ex_q.dst == id_rs;
  assign ld_rt = id_valid && ex_q.valid && ex_q.reg_write && ex_q.mem_to_reg &&
                 ex_q.dst != 5'd0 && id_use_rt && ex_q.dst == id_rt;

`ifdef HAZ_STORE_FWD_EN
  // A store only needs the loaded value in MEM, where fwd_f supplies it.
  assign load_use = ld_rs || (ld_rt && !id_is_sw);
  assign fwd_f    = mem_q.valid && mem_q.is_sw && wb_q.valid && wb_q.reg_write &&
                    wb_q.mem_to_reg && mem_q.rt != 5'd0 && wb_q.dst == mem_q.rt;
`else
  assign load_use = ld_rs || ld_rt;
  assign fwd_f    = 1'b0;
`endif

  assign md_haz = id_valid && (state_q == BUSY) && (id_is_muldiv || id_reads_hilo);
  assign stall  = load_use || md_haz;
  assign launch = id_valid && id_is_muldiv && !stall && !ex_branch_taken;

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs LAT-1 down to 0 in BUSY, giving MULDIV_LAT busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign muldiv_busy = (state_q == BUSY);
  assign md_state    = state_q;

  logic unused_bits;
  assign unused_bits = ^{wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt, wb_q.is_sw, wb_q.mem_to_reg};

endmodule

// File: tb/tb_hazard_sched.sv
// Randomized plus directed bench for hazard_sched against an instruction-level pipeline model.
module tb_hazard_sched;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_use_rs, id_use_rt, id_is_sw, id_reg_write, id_mem_to_reg;
  logic       id_is_muldiv, id_reads_hilo, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble, fwd_f, muldiv_busy, md_state;
  logic [1:0] fwd_a, fwd_b;

  hazard_sched #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_sw(id_is_sw), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_is_muldiv(id_is_muldiv),
    .id_reads_hilo(id_reads_hilo), .ex_branch_taken(ex_branch_taken),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_f(fwd_f),
    .muldiv_busy(muldiv_busy), .md_state(md_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       is_sw;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       is_muldiv;
    logic       reads_hilo;
  } instr_t;

  // Reference model: instructions occupying EX/MEM/WB and remaining mul/div busy cycles
  instr_t m_ex, m_mem, m_wb;
  int     busy_left;
  logic   last_stall;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic instr_t mk_lw(input int dst, input int base);
    instr_t i = '0;
    i.valid = 1; i.rs = 5'(base); i.use_rs = 1; i.dst = 5'(dst);
    i.reg_write = 1; i.mem_to_reg = 1;
    return i;
  endfunction

  function automatic instr_t mk_alu(input int dst, input int rs, input int rt);
    instr_t i = '0;
    i.valid = 1; i.rs = 5'(rs); i.rt = 5'(rt); i.use_rs = 1; i.use_rt = 1;
    i.dst = 5'(dst); i.reg_write = 1;
    return i;
  endfunction

  function automatic instr_t mk_sw(input int rt, input int base);
    instr_t i = '0;
    i.valid = 1; i.rs = 5'(base); i.rt = 5'(rt); i.use_rs = 1; i.use_rt = 1; i.is_sw = 1;
    return i;
  endfunction

  function automatic instr_t mk_mult(input int rs, input int rt);
    instr_t i = '0;
    i.valid = 1; i.rs = 5'(rs); i.rt = 5'(rt); i.use_rs = 1; i.use_rt = 1; i.is_muldiv = 1;
    return i;
  endfunction

  function automatic instr_t mk_mflo(input int dst);
    instr_t i = '0;
    i.valid = 1; i.dst = 5'(dst); i.reg_write = 1; i.reads_hilo = 1;
    return i;
  endfunction

  function automatic instr_t mk_rand();
    instr_t i;
    i.valid      = ($urandom_range(0, 7) != 0);
    i.rs         = 5'($urandom_range(0, 7));
    i.rt         = 5'($urandom_range(0, 7));
    i.use_rs     = 1'($urandom_range(0, 1));
    i.use_rt     = 1'($urandom_range(0, 1));
    i.is_sw      = ($urandom_range(0, 3) == 0);
    i.dst        = 5'($urandom_range(0, 7));
    i.reg_write  = 1'($urandom_range(0, 1));
    i.mem_to_reg = 1'($urandom_range(0, 1));
    i.is_muldiv  = ($urandom_range(0, 5) == 0);
    i.reads_hilo = ($urandom_range(0, 5) == 0);
    return i;
  endfunction

  // Which earlier result feeds a source operand of the instruction in EX
  function automatic logic [1:0] src_fwd(input logic [4:0] r, input logic u);
    if (!m_ex.valid || !u || r == 5'd0) return 2'b00;
    if (m_mem.valid && m_mem.reg_write && !m_mem.mem_to_reg && m_mem.dst == r) return 2'b10;
    if (m_wb.valid && m_wb.reg_write && m_wb.dst == r) return 2'b01;
    return 2'b00;
  endfunction

  // Driver: apply one cycle of ID/branch/reset inputs, predict outputs, advance the model
  task automatic step(input instr_t i, input logic br, input logic rst, input string tag);
    logic lu_rs, lu_rt, load_use, md, stall, flush, sf;
    @(negedge clk);
    rst_n = rst;
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_is_sw = i.is_sw; id_dst = i.dst; id_reg_write = i.reg_write;
    id_mem_to_reg = i.mem_to_reg; id_is_muldiv = i.is_muldiv; id_reads_hilo = i.reads_hilo;
    ex_branch_taken = br;
    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; busy_left = 0;
    end
    lu_rs = i.valid && m_ex.valid && m_ex.reg_write && m_ex.mem_to_reg && m_ex.dst != 0 &&
            i.use_rs && m_ex.dst == i.rs;
    lu_rt = i.valid && m_ex.valid && m_ex.reg_write && m_ex.mem_to_reg && m_ex.dst != 0 &&
            i.use_rt && m_ex.dst == i.rt;
`ifdef HAZ_STORE_FWD_EN
    load_use = lu_rs || (lu_rt && !i.is_sw);
    sf = m_mem.valid && m_mem.is_sw && m_wb.valid && m_wb.reg_write && m_wb.mem_to_reg &&
         m_mem.rt != 0 && m_wb.dst == m_mem.rt;
`else
    load_use = lu_rs || lu_rt;
    sf = 1'b0;
`endif
    md    = i.valid && busy_left > 0 && (i.is_muldiv || i.reads_hilo);
    stall = load_use || md;
    flush = br;
    exp_q.push_back({!stall || flush, !stall || flush, flush, stall || flush,
                     src_fwd(m_ex.rs, m_ex.use_rs), src_fwd(m_ex.rt, m_ex.use_rt),
                     sf, busy_left > 0});
    tag_q.push_back(tag);
    last_stall = stall && !flush;
    if (rst) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (stall || flush || !i.valid) ? instr_t'('0) : i;
      if (busy_left > 0) busy_left--;
      if (i.valid && i.is_muldiv && !stall && !flush) busy_left = LAT;
    end
  endtask

  // Issue an instruction, repeating it while the model says ID is held
  task automatic issue(input instr_t i, input string tag);
    int guard = 0;
    step(i, 1'b0, 1'b1, tag);
    while (last_stall && guard < 80) begin
      step(i, 1'b0, 1'b1, tag);
      guard++;
    end
  endtask

  task automatic nops(input int n, input string tag);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b1, tag);
  endtask

  // Monitor / scoreboard: outputs settle every cycle, compare against the queued prediction
  always @(negedge clk) begin
    logic [9:0] act, exp_v;
    string t;
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, fwd_a, fwd_b, fwd_f, muldiv_busy};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s @%0t: got pcwe/ifwe/flush/bub/fa/fb/ff/busy=%b required %b",
                 t, $time, act, exp_v);
      end
    end
  end

  initial begin
    instr_t cur;
    m_ex = '0; m_mem = '0; m_wb = '0; busy_left = 0; last_stall = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_sw = 0;
    id_dst = 0; id_reg_write = 0; id_mem_to_reg = 0; id_is_muldiv = 0; id_reads_hilo = 0;
    ex_branch_taken = 0;

    for (int k = 0; k < 3; k++) step(mk_rand(), 1'b0, 1'b0, "reset_hold");
    nops(2, "reset_release");

    issue(mk_lw(5, 1), "lu_lw");
    issue(mk_alu(6, 5, 7), "lu_add");
    nops(4, "lu_drain");

    issue(mk_lw(5, 1), "ls_lw");
    issue(mk_sw(5, 8), "ls_sw");
    nops(4, "ls_drain");

    issue(mk_alu(3, 1, 2), "fwd_add1");
    issue(mk_alu(3, 1, 2), "fwd_add2");
    issue(mk_alu(4, 3, 3), "fwd_use");
    nops(2, "fwd_drain");
    issue(mk_alu(0, 1, 2), "zero_add1");
    issue(mk_alu(0, 1, 2), "zero_add2");
    issue(mk_alu(4, 0, 0), "zero_use");
    nops(2, "zero_drain");

    issue(mk_mult(1, 2), "md_mult");
    issue(mk_mflo(9), "md_mflo");
    nops(6, "md_drain");

    issue(mk_lw(5, 1), "flush_lw");
    step(mk_alu(6, 5, 7), 1'b1, 1'b1, "flush_over_stall");
    nops(3, "flush_drain");
    step(mk_mult(1, 2), 1'b1, 1'b1, "flush_mult");
    nops(3, "flush_mult_idle");

    issue(mk_mult(1, 2), "rst_mult");
    nops(2, "rst_busy");
    step(mk_mflo(2), 1'b0, 1'b0, "rst_mid_busy");
    nops(3, "rst_after");

    cur = mk_rand();
    for (int c = 0; c < 600; c++) begin
      logic br, rst;
      br  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) != 0);
      step(cur, br, rst, "random");
      if (!last_stall || !rst) cur = mk_rand();
    end
    nops(2, "final_drain");

    repeat (2) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the 5-stage MIPS core. It tracks a shadow copy of the destination, source and control bits of the ID/EX, EX/MEM and MEM/WB stages. From that state it sequences load-use stalls, branch flushes and multi-cycle mul/div occupancy, and it drives the ALU operand forwarding selects and the store-data (load→store) forwarding select. It sits beside the pipeline registers and owns every pipeline write-enable, flush and bubble control.

## Interface
- MULDIV_LAT, 4, cycles the mul/div unit stays busy after launch; legal range 2..63.

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  5 each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- id_is_sw  in  1  ID instruction is a store; rt is store data only
- id_dst  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_to_reg  in  1  ID instruction is a load
- id_is_muldiv  in  1  ID instruction launches mul/div
- id_reads_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- pc_write_en  out  1  PC may update
- ifid_write_en  out  1  IF/ID register may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- fwd_f  out  1  MEM-stage store data taken from the MEM/WB load data
- muldiv_busy  out  1  mul/div unit occupied

## Operation
- Shadow stages EX, MEM and WB each hold valid, dst, reg_write, mem_to_reg, rs, rt, use_rs, use_rt and is_sw. Every edge shifts ID→EX→MEM→WB. If idex_bubble=1, EX loads valid=0.
- A shadow entry with dst=0 never matches. Register 0 is never forwarded, and no stall is ever raised for register 0.
- fwd_a is computed from the EX entry's rs and use_rs:
  - 10 if MEM is valid, reg_write=1, mem_to_reg=0 and MEM.dst equals the source;
  - else 01 if WB is valid, reg_write=1 and WB.dst equals the source;
  - else 00.
- fwd_b follows the same rules using rt and use_rt. MEM takes priority over WB.
- fwd_f=1 when all of these hold: MEM is valid, MEM.is_sw=1, WB is valid, WB.reg_write=1, WB.mem_to_reg=1, and WB.dst equals MEM.rt (nonzero).
- A load-use hazard exists when all of these hold:
  - id_valid=1;
  - EX is valid with reg_write=1 and mem_to_reg=1;
  - EX.dst equals id_rs with id_use_rs=1, or EX.dst equals id_rt with id_use_rt=1.
  - Exception: if id_is_sw=1 and the match is on rt only, there is no hazard; fwd_f covers it.
- A mul/div hazard exists when id_valid=1, muldiv_busy=1, and id_is_muldiv or id_reads_hilo is set.
- Stall = load-use hazard or mul/div hazard. During a stall: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
- Flush (ex_branch_taken=1): ifid_flush=1, idex_bubble=1, pc_write_en=1, ifid_write_en=1. Flush has priority over stall.
- The mul/div FSM has two states:
  - IDLE→BUSY at the edge where an ID instruction with id_is_muldiv moves into EX (no stall, no flush). The down-counter loads MULDIV_LAT−1.
  - In BUSY the counter decrements each cycle; BUSY→IDLE at the edge where the counter is 0.
  - muldiv_busy=1 exactly in BUSY. This gives MULDIV_LAT high cycles.
  - A launch is never accepted in BUSY, because it stalls.

## Timing
- All outputs are combinational from the registered shadow/FSM state and the current ID and branch inputs. There is no added latency.
- After reset, and with all inputs 0: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00, fwd_f=0, muldiv_busy=0.
- Load-use stall lasts exactly 1 cycle. At the next edge the load advances to MEM, and the stalled instruction then sees no hazard.
- Flush in the same cycle as a mul/div launch candidate in ID: no launch, FSM stays IDLE.
- Asserting rst_n=0 mid-stall or mid-BUSY immediately empties all shadow stages and returns the FSM to IDLE with the counter at 0.

## Configuration
- HAZ_STORE_FWD_EN defined: fwd_f is generated as above, and the sw-rt-only exception applies (a load followed immediately by a store of the loaded register causes no stall).
- HAZ_STORE_FWD_EN undefined: fwd_f is tied to 0, and the exception is removed. A store whose rt matches a load in EX stalls 1 cycle, and the store data then arrives via fwd_b=01.

## Test plan
- Reset: hold rst_n=0, drive random ID inputs, release → all outputs at reset values, muldiv_busy=0.
- lw $5 followed by add $6,$5,$7 → 1 cycle with pc_write_en=0 and idex_bubble=1. Two cycles after the stall, fwd_a=01 while the add is in EX.
- lw $5 followed by sw $5,0($8):
  - with HAZ_STORE_FWD_EN: no stall, and fwd_f=1 exactly when the sw is in MEM;
  - without it: 1 stall, then fwd_b=01.
- add $3 in consecutive MEM and WB stages with add $4,$3,$3 in EX → fwd_a=fwd_b=10. Same pattern targeting $0 → 00.
- mult with MULDIV_LAT=4, then mflo → muldiv_busy high for 4 cycles, mflo stalled 4 cycles, then released.
- ex_branch_taken=1 while a load-use hazard is present → ifid_flush=1, idex_bubble=1, pc_write_en=1. rst_n pulse during BUSY → muldiv_busy=0 immediately.
